// File: rtl/objseq_pkg.sv
// Shared types and constants for the object line sequencer.
package objseq_pkg;

  localparam int XPOS_W         = 9;
  localparam int TILECODE_W     = 10;
  localparam int LINE_W         = 3;
  localparam int PAL_W          = 4;
  localparam int LB_ADDR_W      = 8;
  localparam int CHARRAM_ADDR_W = TILECODE_W + LINE_W;
  localparam int PIPE_DLY       = 4;
  localparam logic [2:0] DRAIN_CYCLES = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    EMIT  = 3'd3,
    TAIL  = 3'd4,
    DRAIN = 3'd5
  } state_t;

  typedef struct packed {
    logic [XPOS_W-1:0]     xpos;
    logic [TILECODE_W-1:0] tilecode;
    logic [LINE_W-1:0]     line;
    logic [1:0]            width;
    logic                  hflip;
  } cmd_t;

  // Index of the final tile for a width code (1, 2, 4 or 8 tiles).
  function automatic logic [2:0] last_tile(input logic [1:0] width);
    return (3'd1 << width) - 3'd1;
  endfunction

endpackage

// File: rtl/objline_sequencer_if.sv
// Command, CHARRAM, line-latch and line-buffer signals of the object line sequencer.
interface objline_sequencer_if;
  import objseq_pkg::*;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [XPOS_W-1:0]         cmd_xpos;
  logic [PAL_W-1:0]          cmd_palette;
  logic [TILECODE_W-1:0]     cmd_tilecode;
  logic [LINE_W-1:0]         cmd_line;
  logic [1:0]                cmd_width;
  logic                      cmd_hflip;
  logic                      charram_req;
  logic [CHARRAM_ADDR_W-1:0] charram_addr;
  logic                      charram_ack;
  logic                      tilelinelatch_n;
  logic                      colorlatch_n;
  logic [2:0]                pixelsel;
  logic                      wrtime2;
  logic                      pixellatch_wait_n;
  logic                      xpos_d0;
  logic                      lb_wr;
  logic [LB_ADDR_W-1:0]      lb_addr;
  logic                      busy;

  modport master (
    output cmd_valid, cmd_xpos, cmd_palette, cmd_tilecode, cmd_line, cmd_width, cmd_hflip,
    output charram_ack,
    input  cmd_ready, charram_req, charram_addr, tilelinelatch_n, colorlatch_n, pixelsel,
    input  wrtime2, pixellatch_wait_n, xpos_d0, lb_wr, lb_addr, busy
  );

  modport slave (
    input  cmd_valid, cmd_xpos, cmd_palette, cmd_tilecode, cmd_line, cmd_width, cmd_hflip,
    input  charram_ack,
    output cmd_ready, charram_req, charram_addr, tilelinelatch_n, colorlatch_n, pixelsel,
    output wrtime2, pixellatch_wait_n, xpos_d0, lb_wr, lb_addr, busy
  );

endinterface

// File: rtl/objseq_dly4.sv
// Clock-enable gated delay line matching the line latch's internal pipeline depth.
module objseq_dly4
  import objseq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic [LB_ADDR_W:0]   din,
  output logic [LB_ADDR_W:0]   dout
);

  logic [LB_ADDR_W:0] stage_r [PIPE_DLY];

  // Shift {write, address} one stage per enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_DLY; i++) stage_r[i] <= '0;
    end else if (ce) begin
      stage_r[0] <= din;
      for (int i = 1; i < PIPE_DLY; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign dout = stage_r[PIPE_DLY-1];

endmodule

// File: rtl/objline_sequencer.sv
// Sprite line sequencer: fetches tile lines and drives the line-latch / line-buffer bus.
// Optional feature macro OBJSEQ_HFLIP_EN enables horizontal flip of pixel and tile order.
module objline_sequencer
  import objseq_pkg::*;
(
  input  logic          i_EMU_MCLK,
  input  logic          i_EMU_RST_n,
  input  logic          i_EMU_CLK6MPCEN_n,
  objline_sequencer_if.slave bus
);

  logic   ce_s;
  state_t state_r, state_s;
  cmd_t   cmd_r, cmd_s;
  logic [2:0] tile_r, tile_s, drain_r, drain_s, last_s, tsel_s;
  logic [5:0] pix_r, pix_s;
  logic       ack_seen_r, ack_seen_s, accept_s, flip_s, xodd_s;
  logic [TILECODE_W-1:0] tcode_s;
  logic [LB_ADDR_W-1:0]  wr_addr_r, wr_addr_s;

  logic req_r, req_s, tl_n_r, tl_n_s, cl_n_r, cl_n_s, wrtime2_r, wrtime2_s;
  logic wait_n_r, wait_n_s, xpos_d0_r, xpos_d0_s, pre_wr_r, pre_wr_s;
  logic ready_r, ready_s, busy_r, busy_s;
  logic [2:0] pixsel_r, pixsel_s;
  logic [CHARRAM_ADDR_W-1:0] addr_r, addr_s;
  logic [LB_ADDR_W:0] dly_out_s;

  assign ce_s = ~i_EMU_CLK6MPCEN_n;

  // Next-state logic for the command FSM and its counters.
  always_comb begin
    state_s    = state_r;
    cmd_s      = cmd_r;
    tile_s     = tile_r;
    pix_s      = pix_r;
    drain_s    = drain_r;
    ack_seen_s = ack_seen_r;
    accept_s   = 1'b0;
    last_s     = last_tile(cmd_r.width);
    case (state_r)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept_s   = 1'b1;
          cmd_s      = '{xpos: bus.cmd_xpos, tilecode: bus.cmd_tilecode, line: bus.cmd_line,
                         width: bus.cmd_width, hflip: bus.cmd_hflip};
          state_s    = FETCH;
          tile_s     = 3'd0;
          pix_s      = 6'd0;
          drain_s    = 3'd0;
          ack_seen_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        // The ACK may arrive while the previous tile is still draining; remember it.
        drain_s    = (drain_r != 3'd0) ? drain_r - 3'd1 : 3'd0;
        ack_seen_s = ack_seen_r | bus.charram_ack;
        if (ack_seen_s && (drain_r == 3'd0)) begin
          state_s    = LATCH;
          ack_seen_s = 1'b0;
        end else begin
          state_s = FETCH;
        end
      end
      LATCH: state_s = EMIT;
      EMIT: begin
        pix_s = pix_r + 6'd1;
        if (pix_r[2:0] == 3'd7) begin
          drain_s = DRAIN_CYCLES;
          if (tile_r == last_s) begin
            state_s = cmd_r.xpos[0] ? TAIL : DRAIN;
          end else begin
            state_s = FETCH;
            tile_s  = tile_r + 3'd1;
          end
        end else begin
          state_s = EMIT;
        end
      end
      TAIL: begin
        state_s = DRAIN;
        drain_s = DRAIN_CYCLES;
      end
      DRAIN: begin
        if (drain_r <= 3'd1) begin
          state_s = IDLE;
          drain_s = 3'd0;
        end else begin
          state_s = DRAIN;
          drain_s = drain_r - 3'd1;
        end
      end
      default: state_s = IDLE;
    endcase
  end

`ifdef OBJSEQ_HFLIP_EN
  assign flip_s = cmd_s.hflip;
`else
  assign flip_s = 1'b0;
`endif

  // Output decode from next-state values so every output leaves a register.
  always_comb begin
    xodd_s    = cmd_s.xpos[0];
    tsel_s    = flip_s ? (last_tile(cmd_s.width) - tile_s) : tile_s;
    tcode_s   = cmd_s.tilecode + {7'd0, tsel_s};
    req_s     = (state_s == FETCH);
    addr_s    = {tcode_s, cmd_s.line};
    tl_n_s    = ~(state_s == LATCH);
    cl_n_s    = ~accept_s;
    pixsel_s  = 3'd0;
    wrtime2_s = 1'b1;
    wait_n_s  = 1'b1;
    pre_wr_s  = 1'b0;
    case (state_s)
      EMIT: begin
        pixsel_s  = flip_s ? ~pix_s[2:0] : pix_s[2:0];
        wrtime2_s = xodd_s ^ pix_s[0];
        pre_wr_s  = xodd_s ^ pix_s[0];
        wait_n_s  = ~(xodd_s & (pix_s == 6'd0));
      end
      TAIL: begin
        wait_n_s = 1'b0;
        pre_wr_s = 1'b1;
      end
      default: begin
        pre_wr_s = 1'b0;
      end
    endcase
    xpos_d0_s = accept_s ? bus.cmd_xpos[0] : xpos_d0_r;
    wr_addr_s = accept_s ? bus.cmd_xpos[XPOS_W-1:1]
                         : (pre_wr_r ? wr_addr_r + 8'd1 : wr_addr_r);
    ready_s   = (state_s == IDLE);
    busy_s    = ~ready_s;
  end

  // State, counters and registered outputs; advance only on enabled edges.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) begin
      state_r    <= IDLE;
      cmd_r      <= '0;
      tile_r     <= 3'd0;
      pix_r      <= 6'd0;
      drain_r    <= 3'd0;
      ack_seen_r <= 1'b0;
      wr_addr_r  <= 8'd0;
      req_r      <= 1'b0;
      addr_r     <= 13'd0;
      tl_n_r     <= 1'b1;
      cl_n_r     <= 1'b1;
      pixsel_r   <= 3'd0;
      wrtime2_r  <= 1'b1;
      wait_n_r   <= 1'b1;
      xpos_d0_r  <= 1'b0;
      pre_wr_r   <= 1'b0;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
    end else if (ce_s) begin
      state_r    <= state_s;
      cmd_r      <= cmd_s;
      tile_r     <= tile_s;
      pix_r      <= pix_s;
      drain_r    <= drain_s;
      ack_seen_r <= ack_seen_s;
      wr_addr_r  <= wr_addr_s;
      req_r      <= req_s;
      addr_r     <= addr_s;
      tl_n_r     <= tl_n_s;
      cl_n_r     <= cl_n_s;
      pixsel_r   <= pixsel_s;
      wrtime2_r  <= wrtime2_s;
      wait_n_r   <= wait_n_s;
      xpos_d0_r  <= xpos_d0_s;
      pre_wr_r   <= pre_wr_s;
      ready_r    <= ready_s;
      busy_r     <= busy_s;
    end
  end

  objseq_dly4 u_dly (
    .clk   (i_EMU_MCLK),
    .rst_n (i_EMU_RST_n),
    .ce    (ce_s),
    .din   ({pre_wr_r, wr_addr_r}),
    .dout  (dly_out_s)
  );

  assign bus.cmd_ready         = ready_r;
  assign bus.charram_req       = req_r;
  assign bus.charram_addr      = addr_r;
  assign bus.tilelinelatch_n   = tl_n_r;
  assign bus.colorlatch_n      = cl_n_r;
  assign bus.pixelsel          = pixsel_r;
  assign bus.wrtime2           = wrtime2_r;
  assign bus.pixellatch_wait_n = wait_n_r;
  assign bus.xpos_d0           = xpos_d0_r;
  assign bus.lb_wr             = dly_out_s[LB_ADDR_W];
  assign bus.lb_addr           = dly_out_s[LB_ADDR_W-1:0];
  assign bus.busy              = busy_r;

endmodule

// File: tb/tb_objline_sequencer.sv
// Directed self-checking bench for objline_sequencer; expectations follow OBJSEQ_HFLIP_EN.
module tb_objline_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  objline_sequencer_if bus ();

  objline_sequencer dut (
    .i_EMU_MCLK        (clk),
    .i_EMU_RST_n       (rst_n),
    .i_EMU_CLK6MPCEN_n (cen_n),
    .bus               (bus)
  );

  always #5 clk = ~clk;

  logic       s_req [48], s_tl [48], s_wt [48], s_wait [48], s_wr [48];
  logic       s_ready [48], s_busy [48], s_cl [48], s_d0 [48];
  logic [2:0] s_ps [48];
  logic [12:0] s_addr [48];
  logic [7:0] s_la [48];
  int wc[$], wa[$], lc[$], lt[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One command, one CE cycle per clock; tile 1 ACK is held back dly1 cycles.
  task automatic run_cmd(input logic [8:0] x, input logic [9:0] tc, input logic [2:0] ln,
                         input logic [1:0] w, input logic hf, input int dly1, input int ncyc);
    int tile_i = 0;
    int req_cnt = 0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      s_req[n] = bus.charram_req;  s_tl[n] = bus.tilelinelatch_n; s_wt[n] = bus.wrtime2;
      s_wait[n] = bus.pixellatch_wait_n; s_wr[n] = bus.lb_wr; s_ready[n] = bus.cmd_ready;
      s_busy[n] = bus.busy; s_cl[n] = bus.colorlatch_n; s_d0[n] = bus.xpos_d0;
      s_ps[n] = bus.pixelsel; s_addr[n] = bus.charram_addr; s_la[n] = bus.lb_addr;
      bus.cmd_valid = (n == 0);
      if (n == 0) begin
        bus.cmd_xpos = x; bus.cmd_tilecode = tc; bus.cmd_line = ln;
        bus.cmd_width = w; bus.cmd_hflip = hf; bus.cmd_palette = 4'h5;
      end
      if (bus.charram_req) begin
        bus.charram_ack = (req_cnt >= ((tile_i == 1) ? dly1 : 0));
        req_cnt++;
      end else begin
        if (req_cnt != 0) tile_i++;
        req_cnt = 0;
        bus.charram_ack = 1'b0;
      end
    end
    bus.cmd_valid = 1'b0;
    bus.charram_ack = 1'b0;
    wc.delete(); wa.delete(); lc.delete(); lt.delete();
    for (int n = 0; n < ncyc; n++) begin
      if (s_wr[n]) begin wc.push_back(n); wa.push_back(int'(s_la[n])); end
      if (!s_tl[n]) begin lc.push_back(n); lt.push_back(int'(s_addr[n][12:3])); end
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_xpos = 9'd0; bus.cmd_palette = 4'd0; bus.cmd_tilecode = 10'd0;
    bus.cmd_line = 3'd0; bus.cmd_width = 2'd0; bus.cmd_hflip = 1'b0; bus.charram_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_ready", bus.cmd_ready, 1);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_tl", bus.tilelinelatch_n, 1);
    check_val("rst_wt", bus.wrtime2, 1);
    check_val("rst_lbwr", bus.lb_wr, 0);
    rst_n = 1'b1;

    begin : t_a
      int ec[4] = '{8, 10, 12, 14};
      run_cmd(9'h010, 10'h123, 3'd5, 2'd0, 1'b0, 0, 18);
      check_val("A_ready0", s_ready[0], 1);
      check_val("A_req1", s_req[1], 1);
      check_val("A_cl1", s_cl[1], 0);
      check_val("A_addr1", s_addr[1], 13'h091D);
      check_val("A_tl2", s_tl[2], 0);
      check_val("A_req2", s_req[2], 0);
      check_val("A_wt3", s_wt[3], 0);
      check_val("A_wt4", s_wt[4], 1);
      for (int n = 3; n <= 10; n++) check_val($sformatf("A_ps%0d", n), s_ps[n], n - 3);
      check_val("A_nwr", wc.size(), 4);
      for (int i = 0; i < 4; i++) begin
        check_val($sformatf("A_wcyc%0d", i), wc[i], ec[i]);
        check_val($sformatf("A_wadr%0d", i), wa[i], 8 + i);
      end
      check_val("A_rdy14", s_ready[14], 0);
      check_val("A_busy14", s_busy[14], 1);
      check_val("A_rdy15", s_ready[15], 1);
      check_val("A_busy15", s_busy[15], 0);
    end

    begin : t_b
      int ec[5] = '{7, 9, 11, 13, 15};
      run_cmd(9'h011, 10'h001, 3'd0, 2'd0, 1'b0, 0, 20);
      check_val("B_nwr", wc.size(), 5);
      for (int i = 0; i < 5; i++) begin
        check_val($sformatf("B_wcyc%0d", i), wc[i], ec[i]);
        check_val($sformatf("B_wadr%0d", i), wa[i], 8 + i);
      end
      for (int n = 1; n <= 14; n++)
        check_val($sformatf("B_wait%0d", n), s_wait[n], (n == 3 || n == 11) ? 0 : 1);
      check_val("B_wt3", s_wt[3], 1);
      check_val("B_d0", s_d0[5], 1);
      check_val("B_rdy15", s_ready[15], 0);
      check_val("B_rdy16", s_ready[16], 1);
    end

    begin : t_c
      run_cmd(9'h020, 10'h3FF, 3'd1, 2'd1, 1'b0, 10, 40);
      check_val("C_nlat", lc.size(), 2);
      check_val("C_lat0", lc[0], 2);
      check_val("C_lat1", lc[1], 22);
      check_val("C_tc0", lt[0], 10'h3FF);
      check_val("C_tc1", lt[1], 10'h000);
      for (int n = 11; n <= 22; n++) check_val($sformatf("C_wt%0d", n), s_wt[n], 1);
      for (int n = 15; n <= 27; n++) check_val($sformatf("C_wr%0d", n), s_wr[n], 0);
      check_val("C_nwr", wc.size(), 8);
      check_val("C_wlast", wc[7], 34);
      check_val("C_alast", wa[7], 8'h17);
      check_val("C_rdy35", s_ready[35], 1);
    end

    begin : t_d
      int ec[8] = '{8, 10, 12, 14, 22, 24, 26, 28};
      int ea[8] = '{8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      run_cmd(9'h1FE, 10'h010, 3'd0, 2'd1, 1'b0, 0, 32);
      check_val("D_nwr", wc.size(), 8);
      for (int i = 0; i < 8; i++) begin
        check_val($sformatf("D_wcyc%0d", i), wc[i], ec[i]);
        check_val($sformatf("D_wadr%0d", i), wa[i], ea[i]);
      end
      check_val("D_lat1", lc[1], 16);
      check_val("D_rdy29", s_ready[29], 1);
    end

    begin : t_e
      logic fl;
`ifdef OBJSEQ_HFLIP_EN
      fl = 1'b1;
`else
      fl = 1'b0;
`endif
      run_cmd(9'h000, 10'h040, 3'd0, 2'd1, 1'b1, 0, 32);
      check_val("E_tc0", lt[0], fl ? 10'h041 : 10'h040);
      check_val("E_tc1", lt[1], fl ? 10'h040 : 10'h041);
      for (int n = 3; n <= 10; n++)
        check_val($sformatf("E_ps%0d", n), s_ps[n], fl ? 10 - n : n - 3);
      for (int n = 17; n <= 24; n++)
        check_val($sformatf("E_ps%0d", n), s_ps[n], fl ? 24 - n : n - 17);
    end

    begin : t_f
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_xpos = 9'h010; bus.cmd_tilecode = 10'h055;
      bus.cmd_line = 3'd0; bus.cmd_width = 2'd0; bus.cmd_hflip = 1'b0;
      for (int n = 1; n <= 5; n++) begin
        @(negedge clk);
        if (n == 5) begin
          check_val("F_ready_busy", bus.cmd_ready, 0);
          check_val("F_busy", bus.busy, 1);
          check_val("F_ps", bus.pixelsel, 2);
          check_val("F_addr_hold", bus.charram_addr, 13'h02A8);
        end
        bus.charram_ack = bus.charram_req;
        if (n == 1) begin
          bus.cmd_xpos = 9'h021; bus.cmd_tilecode = 10'h0AA; bus.cmd_line = 3'd2;
        end
      end
      #2 rst_n = 1'b0;
      #1;
      check_val("F_r_ps", bus.pixelsel, 0);
      check_val("F_r_tl", bus.tilelinelatch_n, 1);
      check_val("F_r_cl", bus.colorlatch_n, 1);
      check_val("F_r_wt", bus.wrtime2, 1);
      check_val("F_r_wait", bus.pixellatch_wait_n, 1);
      check_val("F_r_req", bus.charram_req, 0);
      check_val("F_r_addr", bus.charram_addr, 0);
      check_val("F_r_lbwr", bus.lb_wr, 0);
      check_val("F_r_lba", bus.lb_addr, 0);
      check_val("F_r_busy", bus.busy, 0);
      check_val("F_r_ready", bus.cmd_ready, 1);
      bus.charram_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_val("F_rel_ready", bus.cmd_ready, 1);
      @(negedge clk);
      check_val("F_acc_req", bus.charram_req, 1);
      check_val("F_acc_addr", bus.charram_addr, 13'h0552);
      check_val("F_acc_d0", bus.xpos_d0, 1);
      check_val("F_acc_cl", bus.colorlatch_n, 0);
      bus.cmd_valid = 1'b0;
      for (int n = 0; n < 22; n++) begin
        bus.charram_ack = bus.charram_req;
        @(negedge clk);
      end
      bus.charram_ack = 1'b0;
      check_val("F_end_ready", bus.cmd_ready, 1);
    end

    begin : t_g
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_xpos = 9'h010; bus.cmd_tilecode = 10'h000;
      bus.cmd_width = 2'd0; bus.cmd_hflip = 1'b0;
      for (int n = 1; n <= 4; n++) begin
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.charram_ack = bus.charram_req;
      end
      check_val("G_ps_before", bus.pixelsel, 1);
      cen_n = 1'b1;
      for (int n = 0; n < 3; n++) begin
        @(negedge clk);
        check_val($sformatf("G_ps_hold%0d", n), bus.pixelsel, 1);
        check_val($sformatf("G_wt_hold%0d", n), bus.wrtime2, 1);
      end
      cen_n = 1'b0;
      @(negedge clk);
      check_val("G_ps_after", bus.pixelsel, 2);
      repeat (16) @(negedge clk);
      bus.charram_ack = 1'b0;
      check_val("G_end_ready", bus.cmd_ready, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/objline_sequencer.md
# objline_sequencer

Sprite line sequencer that drives the object line-latch control bus. It accepts one sprite-line command at a time and fetches each 8-pixel tile line from CHARRAM over a request/acknowledge handshake. It then strobes the tile-line and palette latches and steps the pixel selector and write-timing signals. It also issues line-buffer write strobes and addresses, aligned to the latch's internal 4-cycle pipeline. It sits between the object attribute scanner and the line latch / line-buffer DRAM.

## Interface
Parameters: none; widths live in `objseq_pkg`.
- i_EMU_MCLK  in  1  master clock
- i_EMU_RST_n  in  1  asynchronous active-low reset
- i_EMU_CLK6MPCEN_n  in  1  active-low clock enable; all state advances only on enabled edges ("CE cycles")
- i_CMD_VALID / o_CMD_READY  in/out  1  command handshake; accepted on a CE cycle with both high
- i_CMD_XPOS  in  9  first pixel x position
- i_CMD_PALETTE  in  4  palette code
- i_CMD_TILECODE  in  10  first tile code
- i_CMD_LINE  in  3  tile row
- i_CMD_WIDTH  in  2  tile count = 1, 2, 4 or 8
- i_CMD_HFLIP  in  1  horizontal flip
- o_CHARRAM_REQ  out  1  fetch request
- o_CHARRAM_ADDR  out  13  {tile code, line}
- i_CHARRAM_ACK  in  1  GFXDATA valid; CHARRAM holds the data until the next REQ
- o_TILELINELATCH_n, o_COLORLATCH_n  out  1  latch strobes
- o_PIXELSEL  out  3  pixel select
- o_WRTIME2, o_PIXELLATCH_WAIT_n, o_XPOS_D0  out  1  line-latch write timing
- o_LB_WR  out  1  line-buffer write, pipeline-aligned
- o_LB_ADDR  out  8  line-buffer pair address
- o_BUSY  out  1  command in progress or pipeline draining

## Operation
- Reset values:
  - outputs: TILELINELATCH_n=1, COLORLATCH_n=1, PIXELSEL=0, WRTIME2=1, PIXELLATCH_WAIT_n=1, XPOS_D0=0, CHARRAM_REQ=0, CHARRAM_ADDR=0, LB_WR=0, LB_ADDR=0, BUSY=0, CMD_READY=1
  - FSM state: IDLE
- States: IDLE, FETCH, LATCH, EMIT, TAIL, DRAIN.
- IDLE:
  - READY=1.
  - On accept: register the command, assert COLORLATCH_n=0 for one CE cycle, set XPOS_D0=XPOS[0] (held until the next accept), go to FETCH with tile index t=0.
- FETCH:
  - REQ=1.
  - ADDR={(TILECODE+t') mod 1024, LINE}, with t'=t, or W-1-t when flipped.
  - Leave FETCH once ACK has been seen and the drain counter is 0; then go to LATCH.
  - ACK is ignored in every other state.
- LATCH: one CE cycle; TILELINELATCH_n=0, REQ=0; then go to EMIT.
- EMIT: k = global pixel index 0..8W-1.
  - PIXELSEL = k[2:0], or 7-k[2:0] when flipped.
  - Even x: WRTIME2=k[0]; pre-delay write on odd k.
  - Odd x: WRTIME2=~k[0]; pre-delay write on even k. At k=0, PIXELLATCH_WAIT_n=0 (lone first pixel).
  - After pixel 7 of a non-final tile: load the drain counter with 4 and go to FETCH with t+1.
  - After the final tile: odd x goes to TAIL, even x goes to DRAIN.
- TAIL: one CE cycle; WRTIME2=1, PIXELLATCH_WAIT_n=0, pre-delay write (lone last pixel).
- DRAIN: drain counter 4→0; then IDLE.
- Outside EMIT/TAIL: WRTIME2=1 and PIXELLATCH_WAIT_n=1, so no pixel latch and no write.
- Write address: the n-th pre-delay write uses address (XPOS[8:1]+n) mod 256.
  - Write count: 4W for even x, 4W+1 for odd x.
- A VALID asserted while busy is held off (READY=0); command fields are not sampled.
- Async reset mid-command returns to IDLE immediately, clears the delay line, and drops any pending ACK.

## Timing
- Accept at CE cycle 0 → REQ at cycle 1.
- With ACK at cycle 1 → TILELINELATCH_n low at cycle 2 → EMIT k=0 at cycle 3.
- o_LB_WR and o_LB_ADDR equal the pre-delay values delayed exactly 4 CE cycles.
- Minimum tile-to-tile gap is 6 CE cycles: 4 drain, LATCH, plus ACK wait overlapped with drain.
- READY returns 5 CE cycles after the last EMIT/TAIL cycle.
- Disabled clock-enable edges change nothing.

## Configuration
- OBJSEQ_HFLIP_EN defined: i_CMD_HFLIP reverses pixel order within each tile and the tile order.
- Undefined: i_CMD_HFLIP is ignored, and the order is always ascending.

## Structure
- objseq_pkg holds:
  - state enum
  - DRAIN_CYCLES=4
  - PIPE_DLY=4
  - field widths (XPOS 9, TILECODE 10, LB_ADDR 8)
- One sub-module, objseq_dly4: a 4-stage CE-gated delay line with async clear, carrying {pre-delay write, address}.

## Test plan
- XPOS=0x10, W=1, immediate ACK:
  - LB_WR high on cycles 8, 10, 12, 14.
  - LB_ADDR 0x08..0x0B.
  - PIXELSEL runs 0..7 over cycles 3..10.
- XPOS=0x11, W=1: 5 writes at LB_ADDR 0x08..0x0C; PIXELLATCH_WAIT_n low at cycle 3 and at TAIL (cycle 11).
- W=2, TILECODE=0x3FF, ACK delayed 10 cycles on tile 1:
  - ADDR tile codes are 0x3FF then 0x000 (wrap).
  - WRTIME2 stays 1 and LB_WR stays 0 during the stall.
- XPOS=0x1FE, W=2: LB_ADDR sequence 0xFF, 0x00, ... wraps mod 256.
- HFLIP=1, W=2, with OBJSEQ_HFLIP_EN: tile order 1,0 and PIXELSEL 7..0; without the macro, tile order 0,1 and PIXELSEL 0..7.
- Reset asserted mid-EMIT, VALID held during busy:
  - All outputs return to reset values at once.
  - READY=1 after release, and the held command is then accepted.
